// File: rtl/vedic_mul_seq16.sv
// vedic_mul_seq16: sequential 16x16 unsigned multiplier built around one 4x4
// vedic multiplier. The 16 nibble-by-nibble partial products go through that
// single vedic_4bit, one per clock. Each one is shifted into place and added
// into a 32-bit accumulator.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   a/b hold valid operands
//   in_ready   operands can be accepted (IDLE only)
//   a, b       16-bit unsigned operands
//   out_valid  p holds a finished product
//   out_ready  consumer accepts p
//   p          32-bit unsigned product
//   busy       a product is in flight or waiting to be taken
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for operands; p still shows the previous product
// MUL   | sweeping the 16 nibble partial products, cnt selects the pair
// DONE  | product ready; held until out_ready

module vedic_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic cross_0;
  logic cross_1;
  logic carry_1;
  logic top;

  assign cross_0 = a[1] & b[0];
  assign cross_1 = a[0] & b[1];
  assign carry_1 = cross_0 & cross_1;
  assign top     = a[1] & b[1];

  assign p[0] = a[0] & b[0];
  assign p[1] = cross_0 ^ cross_1;
  assign p[2] = top ^ carry_1;
  assign p[3] = top & carry_1;
endmodule

module vedic_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q_ll;
  logic [3:0] q_hl;
  logic [3:0] q_lh;
  logic [3:0] q_hh;
  logic [5:0] mid;
  logic [3:0] upper;

  vedic_2bit u_ll (.a(a[1:0]), .b(b[1:0]), .p(q_ll));
  vedic_2bit u_hl (.a(a[3:2]), .b(b[1:0]), .p(q_hl));
  vedic_2bit u_lh (.a(a[1:0]), .b(b[3:2]), .p(q_lh));
  vedic_2bit u_hh (.a(a[3:2]), .b(b[3:2]), .p(q_hh));

  // The two cross terms plus the carry-in from the low block are at most
  // 9 + 9 + 3, so 6 bits is plenty. The top nibble cannot overflow,
  // because 15*15 fits in 8 bits.
  assign mid   = {2'b00, q_hl} + {2'b00, q_lh} + {4'b0000, q_ll[3:2]};
  assign upper = q_hh + mid[5:2];

  assign p = {upper, mid[1:0], q_ll[1:0]};
endmodule

module vedic_mul_seq16 #(
  parameter bit ZERO_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] p,
  output logic        busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [31:0] acc;
  logic [15:0] a_r;
  logic [15:0] b_r;

  logic        accept;
  logic        zero_op;
  logic [1:0]  i_idx;
  logic [1:0]  j_idx;
  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [7:0]  pp;
  logic [4:0]  shamt;
  logic [31:0] pp_sh;

  assign accept  = in_valid & in_ready;
  assign zero_op = (ZERO_SKIP != 1'b0) && ((a == 16'd0) || (b == 16'd0));

  // The low two bits of cnt walk the multiplicand nibbles.
  // The high two bits walk the multiplier nibbles.
  assign i_idx = cnt[1:0];
  assign j_idx = cnt[3:2];
  assign nib_a = a_r[{i_idx, 2'b00} +: 4];
  assign nib_b = b_r[{j_idx, 2'b00} +: 4];

  vedic_4bit u_vedic (.a(nib_a), .b(nib_b), .p(pp));

  // The weight of the partial product is 4*(i+j), at most 24. That leaves
  // the 8-bit partial product fully inside 32 bits.
  assign shamt = {({1'b0, i_idx} + {1'b0, j_idx}), 2'b00};
  assign pp_sh = {24'd0, pp} << shamt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          state_nxt = zero_op ? DONE : MUL;
        end
      end
      MUL: begin
        busy = 1'b1;
        if (cnt == 4'd15) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
      acc <= 32'd0;
      a_r <= 16'd0;
      b_r <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r <= a;
            b_r <= b;
            acc <= 32'd0;
            cnt <= 4'd0;
          end
        end
        MUL: begin
          acc <= acc + pp_sh;
          cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign p = acc;
endmodule

// File: tb/tb_vedic_mul_seq16.sv
// Testbench for vedic_mul_seq16. A reference model predicts the handshake
// outputs and the product every cycle from plain arithmetic. Directed
// vectors with hand-computed literals pin down the products and the
// latencies. A second instance with zero-skip disabled covers the
// full-sweep zero case. Latencies are counted in clock edges after the
// edge that accepts the operands.

module tb_vedic_mul_seq16;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic        busy;

  logic        nz_in_valid;
  logic        nz_in_ready;
  logic [15:0] nz_a;
  logic [15:0] nz_b;
  logic        nz_out_valid;
  logic        nz_out_ready;
  logic [31:0] nz_p;
  logic        nz_busy;

  int n_cmp;
  int n_err;

  vedic_mul_seq16 #(.ZERO_SKIP(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .p(p), .busy(busy)
  );

  vedic_mul_seq16 #(.ZERO_SKIP(1'b0)) u_nz (
    .clk(clk), .rst(rst), .in_valid(nz_in_valid), .in_ready(nz_in_ready),
    .a(nz_a), .b(nz_b), .out_valid(nz_out_valid), .out_ready(nz_out_ready),
    .p(nz_p), .busy(nz_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      if (n_err <= 50)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one operation in flight at a time. Results appear
  // 16 edges after acceptance, or immediately after the accepting edge
  // when an operand is zero.
  logic        m_busy;
  int          m_lat;
  logic [31:0] m_p;
  int          m_acc;
  int          m_res;
  int          dut_res;
  logic        chk_en;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_lat  <= 0;
      m_p    <= 32'd0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy <= 1'b1;
        m_p    <= 32'(a) * 32'(b);
        m_lat  <= ((a == 16'd0) || (b == 16'd0)) ? 0 : 16;
        m_acc  <= m_acc + 1;
      end
    end else if (m_lat != 0) begin
      m_lat <= m_lat - 1;
    end else if (out_ready) begin
      m_busy <= 1'b0;
      m_res  <= m_res + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(!m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_busy && (m_lat == 0)));
      if (!m_busy || (m_lat == 0))
        chk("p", p, m_p);
      if (out_valid && out_ready)
        dut_res <= dut_res + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand pair, then measures the edges until out_valid.
  // With hold > 0 the result is left untaken for that many cycles while
  // in_valid is pulsed, and none of those pulses may be accepted.
  task automatic do_op(input string name, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic [31:0] ep, input int elat, input int hold);
    int g;
    int lat;
    g = 0;
    while (!in_ready && g < 100) begin
      tick();
      g++;
    end
    chk({name, "_ready"}, 32'(in_ready), 32'd1);
    a         = ta;
    b         = tb_;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      in_valid = (hold > 0) && (lat == 3);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    chk({name, "_lat"}, 32'(lat), 32'(elat));
    chk({name, "_p"}, p, ep);
    for (int k = 0; k < hold; k++) begin
      in_valid = k[0];
      tick();
      chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_hold_p"}, p, ep);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (hold > 0) tick();
    tick();
    chk({name, "_back_idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int g;
    int lat;
    int start_acc;
    n_cmp = 0;
    n_err = 0;
    m_acc = 0;
    m_res = 0;
    dut_res = 0;
    chk_en = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    a = 16'd0;
    b = 16'd0;
    out_ready = 1'b1;
    nz_in_valid = 1'b0;
    nz_a = 16'd0;
    nz_b = 16'd0;
    nz_out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_p", p, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    do_op("ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16, 0);
    do_op("1234", 16'h1234, 16'h5678, 32'h06260060, 16, 0);
    do_op("one", 16'h0001, 16'h0001, 32'h00000001, 16, 0);
    do_op("msb", 16'h8000, 16'h0002, 32'h00010000, 16, 0);
    do_op("zero_a", 16'h0000, 16'hABCD, 32'h00000000, 0, 0);
    do_op("zero_b", 16'hABCD, 16'h0000, 32'h00000000, 0, 0);
    do_op("hold", 16'h0003, 16'h0005, 32'h0000000F, 16, 10);

    nz_a = 16'h0000;
    nz_b = 16'hABCD;
    nz_in_valid = 1'b1;
    tick();
    nz_in_valid = 1'b0;
    lat = 0;
    while (!nz_out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("nz_lat", 32'(lat), 32'd16);
    chk("nz_p", nz_p, 32'd0);

    a = 16'h00FF;
    b = 16'h0101;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_p", p, 32'd0);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    do_op("after_abort", 16'h0002, 16'h0003, 32'h00000006, 16, 0);

    start_acc = m_acc;
    g = 0;
    while ((m_acc < start_acc + 1000) && g < 60000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 16'd0 : 16'($urandom);
      tick();
      g++;
    end
    chk("random_budget", 32'(g < 60000), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    g = 0;
    while (m_busy && g < 100) begin
      tick();
      g++;
    end
    tick();
    chk("result_count", 32'(dut_res), 32'(m_res));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
